// File: rtl/mem_port_arbiter.sv
// Instruction/data arbiter in front of one shared single-port SRAM.
// Optional ARB_DATA_PRIO_EN: data port always wins a tie (else round-robin).
module mem_port_arbiter #(
  parameter int MEM_AW = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_read,
  output logic [DATA_W/8-1:0] mem_write,
  output logic [DATA_W-1:0]   mem_DI,
  input  logic [DATA_W-1:0]   mem_DO
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [DATA_W/8-1:0] wr_q, wr_d;
  logic [DATA_W-1:0]   di_q, di_d;
  logic                own_d_q, own_d_d;
  logic                is_wr_q, is_wr_d;
  logic                pick_d;
  logic                resp;

`ifdef ARB_DATA_PRIO_EN
  // Fixed priority: data port takes every tie.
  always_comb pick_d = d_req;
`else
  logic last_d_q, last_d_d;

  // Round-robin: on a tie the port that lost last time wins.
  always_comb pick_d = d_req & (~i_req | ~last_d_q);
`endif

  // Grants only exist in IDLE and never while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state_q == IDLE && !rst) begin
      d_gnt = pick_d;
      i_gnt = i_req & ~pick_d;
    end
  end

  // Next-state and registered memory strobe computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    di_d    = di_q;
    own_d_d = own_d_q;
    is_wr_d = is_wr_q;
`ifndef ARB_DATA_PRIO_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_gnt) begin
          state_d = ACCESS;
          addr_d  = d_addr[MEM_AW+1:2];
          rd_d    = (d_we == '0);
          wr_d    = d_we;
          is_wr_d = (d_we != '0);
          own_d_d = 1'b1;
          if (d_we != '0) di_d = d_wdata;
`ifndef ARB_DATA_PRIO_EN
          last_d_d = 1'b1;
`endif
        end else if (i_gnt) begin
          state_d = ACCESS;
          addr_d  = i_addr[MEM_AW+1:2];
          rd_d    = 1'b1;
          wr_d    = '0;
          is_wr_d = 1'b0;
          own_d_d = 1'b0;
`ifndef ARB_DATA_PRIO_EN
          last_d_d = 1'b0;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        rd_d    = 1'b0;
        wr_d    = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = '0;
      end
    endcase
  end

  // State and memory-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= '0;
      di_q    <= '0;
      own_d_q <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      di_q    <= di_d;
      own_d_q <= own_d_d;
      is_wr_q <= is_wr_d;
    end
  end

`ifndef ARB_DATA_PRIO_EN
  // Round-robin history, starts at the instruction port.
  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`endif

  assign mem_addr  = addr_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_DI    = di_q;

  // SRAM data arrives in RESP; steer it to the owner, zero otherwise.
  always_comb begin
    resp     = (state_q == RESP) && !rst;
    i_rvalid = resp & ~own_d_q;
    d_rvalid = resp & own_d_q;
    i_rdata  = i_rvalid ? mem_DO : '0;
    d_rdata  = (d_rvalid && !is_wr_q) ? mem_DO : '0;
  end

  logic unused_addr;
  assign unused_addr = ^{i_addr[31:MEM_AW+2], i_addr[1:0],
                         d_addr[31:MEM_AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Includes a behavioural synchronous SRAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [13:0] mem_addr;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_DI;
  logic [31:0] mem_DO = '0;

  logic [31:0] mem [0:16383];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_AW(14), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_DI   (mem_DI),
    .mem_DO   (mem_DO)
  );

  always @(posedge clk) begin
    if (mem_read) mem_DO <= mem[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_write[b]) mem[mem_addr][8*b +: 8] <= mem_DI[8*b +: 8];
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic acc_i(string tag, logic [31:0] a,
                       logic [13:0] wa, logic [31:0] exp);
    i_req  = 1'b1;
    i_addr = a;
    #1;
    chk({tag, ".ignt"}, i_gnt, 1);
    chk({tag, ".dgnt"}, d_gnt, 0);
    tick();
    i_req = 1'b0;
    chk({tag, ".mrd"}, mem_read, 1);
    chk({tag, ".mwr"}, mem_write, 0);
    chk({tag, ".maddr"}, mem_addr, wa);
    tick();
    chk({tag, ".irv"}, i_rvalid, 1);
    chk({tag, ".irdata"}, i_rdata, exp);
    chk({tag, ".drv"}, d_rvalid, 0);
    chk({tag, ".mrd0"}, mem_read, 0);
    tick();
    chk({tag, ".irv0"}, i_rvalid, 0);
    chk({tag, ".irdata0"}, i_rdata, 0);
  endtask

  task automatic acc_d(string tag, logic [3:0] we, logic [31:0] a,
                       logic [31:0] wd, logic [13:0] wa,
                       logic [31:0] exp);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    #1;
    chk({tag, ".dgnt"}, d_gnt, 1);
    chk({tag, ".ignt"}, i_gnt, 0);
    tick();
    d_req = 1'b0;
    chk({tag, ".mrd"}, mem_read, (we == 4'b0000));
    chk({tag, ".mwr"}, mem_write, we);
    chk({tag, ".maddr"}, mem_addr, wa);
    if (we != 4'b0000) chk({tag, ".mdi"}, mem_DI, wd);
    tick();
    chk({tag, ".drv"}, d_rvalid, 1);
    chk({tag, ".drdata"}, d_rdata, exp);
    chk({tag, ".irv"}, i_rvalid, 0);
    chk({tag, ".mwr0"}, mem_write, 0);
    tick();
  endtask

  initial begin
    int gi, gd, ri, rd;
    logic ei, ed;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = '0;
    d_addr  = '0;
    d_wdata = '0;
    rst     = 1'b1;
    for (int k = 0; k < 16384; k++) mem[k] = '0;
    mem[14'h10] = 32'h00500093;
    mem[14'h41] = 32'h11223344;
    for (int k = 0; k < 4; k++) begin
      mem[14'h80 + k] = 32'hA000_0000 + k;
      mem[14'hC0 + k] = 32'hD000_0000 + k;
    end

    tick();
    tick();
    chk("rst.mrd", mem_read, 0);
    chk("rst.mwr", mem_write, 0);
    chk("rst.maddr", mem_addr, 0);
    chk("rst.mdi", mem_DI, 0);
    chk("rst.irv", i_rvalid, 0);
    chk("rst.drv", d_rvalid, 0);
    chk("rst.irdata", i_rdata, 0);
    chk("rst.drdata", d_rdata, 0);
    i_req = 1'b1;
    #1;
    chk("rst.ignt", i_gnt, 0);
    i_req = 1'b0;
    rst   = 1'b0;
    #1;

    acc_i("iread", 32'h40, 14'h10, 32'h00500093);
    acc_d("bwr", 4'b0010, 32'h104, 32'h0000AB00, 14'h41, 32'h0);
    acc_d("brd", 4'b0000, 32'h104, 32'h0, 14'h41, 32'h1122AB44);

    d_req  = 1'b1;
    d_we   = 4'b0000;
    d_addr = 32'h104;
    #1;
    chk("mrst.dgnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    chk("mrst.mrd1", mem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.mrd0", mem_read, 0);
    chk("mrst.drv", d_rvalid, 0);
    i_req  = 1'b1;
    i_addr = 32'h40;
    #1;
    chk("mrst.ignt", i_gnt, 1);
    tick();
    i_req = 1'b0;
    chk("mrst.drv1", d_rvalid, 0);
    tick();
    chk("mrst.irv", i_rvalid, 1);
    chk("mrst.irdata", i_rdata, 32'h00500093);
    chk("mrst.drv2", d_rvalid, 0);
    tick();

    acc_i("alias", 32'h0001_0040, 14'h10, 32'h00500093);

    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h40;
    d_req  = 1'b1;
    d_we   = 4'b0000;
    d_addr = 32'h104;
    for (int k = 0; k < 12; k++) begin
      #1;
      ei = 1'b0;
      ed = 1'b0;
      if (k % 3 == 0) begin
`ifdef ARB_DATA_PRIO_EN
        ed = 1'b1;
`else
        ed = ((k / 3) % 2 == 0);
        ei = !ed;
`endif
      end
      chk($sformatf("cont%0d.ignt", k), i_gnt, ei);
      chk($sformatf("cont%0d.dgnt", k), d_gnt, ed);
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;

    do_reset();
    gi = 0;
    gd = 0;
    ri = 0;
    rd = 0;
    for (int c = 0; c < 60 && (ri < 4 || rd < 4); c++) begin
      i_req  = (gi < 4);
      i_addr = 32'h200 + 4 * gi;
      d_req  = (gd < 4);
      d_we   = 4'b0000;
      d_addr = 32'h300 + 4 * gd;
      #1;
      chk("b2b.both", {31'b0, i_rvalid & d_rvalid}, 0);
      if (i_rvalid) begin
        chk($sformatf("b2b.i%0d", ri), i_rdata, 32'hA000_0000 + ri);
        ri++;
      end
      if (d_rvalid) begin
        chk($sformatf("b2b.d%0d", rd), d_rdata, 32'hD000_0000 + rd);
        rd++;
      end
      if (i_gnt) gi++;
      if (d_gnt) gd++;
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("b2b.icount", ri, 4);
    chk("b2b.dcount", rd, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
